seq_decoder: RTL

SEQ_DECODER -- requirements
Module: seq_decoder

---
 rtl/seq_decoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seq_decoder.sv
// Microcoded control sequencer for an 8-bit breadboard-style CPU.
// Steps T0..T4 with fetch, per-opcode execute, halt and programming freeze.
module seq_decoder #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          EARLY_END = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] insn,
    input  logic              prog_mode,
    input  logic              cf,
    input  logic              zf,
    output logic              hlt,
    output logic              mi,
    output logic              ri,
    output logic              ro,
    output logic              io,
    output logic              ii,
    output logic              ai,
    output logic              ao,
    output logic              sumo,
    output logic              sub,
    output logic              bi,
    output logic              oi,
    output logic              ce,
    output logic              co,
    output logic              j,
    output logic              fi,
    output logic [2:0]        step,
    output logic              halted
);

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [3:0] opcode;
    logic [2:0] last_step;
    logic [2:0] step_nxt;
    logic       halted_nxt;
    logic       unused_operand;

    assign opcode         = insn[DATA_W-1 -: 4];
    assign unused_operand = ^insn[DATA_W-5:0];

    // Final microstep of each opcode, used only for variable-length sequencing.
    always_comb begin
        case (opcode)
            OP_LDA, OP_STA: last_step = T3;
            OP_ADD, OP_SUB: last_step = T4;
            default:        last_step = T2;
        endcase
    end

    // Next-state: prog_mode freezes at T0, halt holds, otherwise advance.
    always_comb begin
        step_nxt   = step;
        halted_nxt = halted;
        if (prog_mode) begin
            step_nxt = T0;
        end else if (!halted) begin
            if (step >= T4 || (EARLY_END && step == last_step)) begin
                step_nxt = T0;
            end else begin
                step_nxt = step + 3'd1;
            end
            if (step == T2 && opcode == OP_HLT) begin
                halted_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step   <= T0;
            halted <= 1'b0;
        end else begin
            step   <= step_nxt;
            halted <= halted_nxt;
        end
    end

    // Control-line decode; steps beyond an opcode's last step fall through to all-zero.
    always_comb begin
        hlt  = 1'b0;
        mi   = 1'b0;
        ri   = 1'b0;
        ro   = 1'b0;
        io   = 1'b0;
        ii   = 1'b0;
        ai   = 1'b0;
        ao   = 1'b0;
        sumo = 1'b0;
        sub  = 1'b0;
        bi   = 1'b0;
        oi   = 1'b0;
        ce   = 1'b0;
        co   = 1'b0;
        j    = 1'b0;
        fi   = 1'b0;
        if (step > T4) begin
            hlt = 1'b0;
        end else if (prog_mode || halted) begin
            hlt = 1'b1;
        end else begin
            case (step)
                T0: begin
                    mi = 1'b1;
                    co = 1'b1;
                end
                T1: begin
                    ro = 1'b1;
                    ii = 1'b1;
                    ce = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            mi = 1'b1;
                            io = 1'b1;
                        end
                        OP_LDI: begin
                            io = 1'b1;
                            ai = 1'b1;
                        end
                        OP_JMP: begin
                            io = 1'b1;
                            j  = 1'b1;
                        end
                        OP_JC: begin
                            io = 1'b1;
                            j  = cf;
                        end
                        OP_JZ: begin
                            io = 1'b1;
                            j  = zf;
                        end
                        OP_OUT: begin
                            ao = 1'b1;
                            oi = 1'b1;
                        end
                        OP_HLT:  hlt = 1'b1;
                        default: hlt = 1'b0;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ro = 1'b1;
                            ai = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ro = 1'b1;
                            bi = 1'b1;
                        end
                        OP_STA: begin
                            ao = 1'b1;
                            ri = 1'b1;
                        end
                        default: ro = 1'b0;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        sumo = 1'b1;
                        ai   = 1'b1;
                        fi   = 1'b1;
                        sub  = (opcode == OP_SUB);
                    end
                end
                default: hlt = 1'b0;
            endcase
        end
    end

endmodule
